// File: rtl/mvu_job_scheduler.sv
// mvu_job_scheduler
//   In-order job dispatcher between the host command path and NMVU
//   matrix-vector units. Jobs {mvu, tag} are queued in a small FIFO. The
//   head job is started on its target MVU once that MVU is idle. The
//   scheduler turns done pulses (or watchdog timeouts) into irq pulses and
//   completion records, which are handed out in fixed priority order.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   job_valid/job_ready     job push handshake; job_mvu, job_tag descriptor
//   mvu_start[NMVU]         one-cycle start pulse to each MVU
//   mvu_done[NMVU]          one-cycle done pulse from each MVU
//   mvu_irq[NMVU]           one-cycle irq pulse when a job finishes or times out
//   busy[NMVU]              MVU has an outstanding job (running or awaiting completion)
//   q_count                 FIFO occupancy
//   cmpl_valid/cmpl_ready   completion handshake; cmpl_mvu, cmpl_tag, cmpl_err record
//   err_spurious            sticky: done seen on an MVU that was not running
module mvu_job_scheduler #(
  parameter int NMVU  = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 8,
  parameter int TOW   = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [$clog2(NMVU)-1:0]    job_mvu,
  input  logic [TAGW-1:0]            job_tag,
  output logic [NMVU-1:0]            mvu_start,
  input  logic [NMVU-1:0]            mvu_done,
  output logic [NMVU-1:0]            mvu_irq,
  output logic [NMVU-1:0]            busy,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       cmpl_valid,
  input  logic                       cmpl_ready,
  output logic [$clog2(NMVU)-1:0]    cmpl_mvu,
  output logic [TAGW-1:0]            cmpl_tag,
  output logic                       cmpl_err,
  output logic                       err_spurious
);

  localparam int MW = $clog2(NMVU);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Timeout is taken on the edge where the counter would become all-ones.
  localparam logic [TOW-1:0] WD_LAST = {{(TOW-1){1'b1}}, 1'b0};
  localparam logic [TOW-1:0] WD_ONE  = {{(TOW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PEND = 2'd2
  } mvu_st_e;

  // FIFO storage and pointers
  logic [DEPTH-1:0][MW-1:0]   fifo_mvu_q, fifo_mvu_d;
  logic [DEPTH-1:0][TAGW-1:0] fifo_tag_q, fifo_tag_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;

  // Per-MVU state
  logic [NMVU-1:0][1:0]       st_q, st_d;
  logic [NMVU-1:0][TOW-1:0]   wd_q, wd_d;
  logic [NMVU-1:0][TAGW-1:0]  tag_q, tag_d;
  logic [NMVU-1:0]            err_q, err_d;
  logic [NMVU-1:0]            start_q, start_d, irq_q, irq_d;
  logic                       spur_q, spur_d;

  // Completion record registers
  logic                       cmpl_valid_q, cmpl_valid_d;
  logic [MW-1:0]              cmpl_mvu_q, cmpl_mvu_d;
  logic [TAGW-1:0]            cmpl_tag_q, cmpl_tag_d;
  logic                       cmpl_err_q, cmpl_err_d;

  logic                       job_ready_s, push_s, pop_s, cmpl_hs_s;
  logic [MW-1:0]              head_mvu_s, sel_s;
  logic [TAGW-1:0]            head_tag_s;
  logic [NMVU-1:0]            pend_nxt_s, busy_s;

  assign job_ready_s = (count_q < CW'(DEPTH));
  assign push_s      = job_valid && job_ready_s;
  assign head_mvu_s  = fifo_mvu_q[rd_ptr_q];
  assign head_tag_s  = fifo_tag_q[rd_ptr_q];
  // Dispatch looks only at registered state, so a slot freed by a handshake
  // this cycle is reused one cycle later.
  assign pop_s       = (count_q != CW'(0)) && (st_q[head_mvu_s] == ST_IDLE);
  assign cmpl_hs_s   = cmpl_valid_q && cmpl_ready;

  // FIFO next state: write on push, advance head on pop.
  always_comb begin
    fifo_mvu_d = fifo_mvu_q;
    fifo_tag_d = fifo_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_s) begin
      fifo_mvu_d[wr_ptr_q] = job_mvu;
      fifo_tag_d[wr_ptr_q] = job_tag;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Per-MVU IDLE/BUSY/PEND transitions, watchdog, dispatch and pulses.
  always_comb begin
    st_d    = st_q;
    wd_d    = wd_q;
    tag_d   = tag_q;
    err_d   = err_q;
    irq_d   = '0;
    start_d = '0;
    spur_d  = spur_q;
    for (int i = 0; i < NMVU; i++) begin
      if (st_q[i] == ST_BUSY) begin
        // done has priority over a coinciding timeout
        if (mvu_done[i]) begin
          st_d[i]  = ST_PEND;
          err_d[i] = 1'b0;
          irq_d[i] = 1'b1;
        end else if (wd_q[i] == WD_LAST) begin
          st_d[i]  = ST_PEND;
          err_d[i] = 1'b1;
          irq_d[i] = 1'b1;
        end else begin
          wd_d[i] = wd_q[i] + WD_ONE;
        end
      end else begin
        spur_d = spur_d | mvu_done[i];
      end
    end
    if (cmpl_hs_s) begin
      st_d[cmpl_mvu_q] = ST_IDLE;
    end else begin
      st_d = st_d;
    end
    if (pop_s) begin
      st_d[head_mvu_s]    = ST_BUSY;
      wd_d[head_mvu_s]    = '0;
      tag_d[head_mvu_s]   = head_tag_s;
      start_d[head_mvu_s] = 1'b1;
    end else begin
      start_d = '0;
    end
  end

  // Completion record: held while offered and not accepted, otherwise
  // reloaded with the lowest-index MVU that will be pending next cycle.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NMVU; i++) begin
      pend_nxt_s[i] = (st_d[i] == ST_PEND);
    end
    for (int i = NMVU - 1; i >= 0; i--) begin
      if (pend_nxt_s[i]) begin
        sel_s = MW'(i);
      end else begin
        sel_s = sel_s;
      end
    end
    if (cmpl_valid_q && !cmpl_ready) begin
      cmpl_valid_d = cmpl_valid_q;
      cmpl_mvu_d   = cmpl_mvu_q;
      cmpl_tag_d   = cmpl_tag_q;
      cmpl_err_d   = cmpl_err_q;
    end else if (|pend_nxt_s) begin
      cmpl_valid_d = 1'b1;
      cmpl_mvu_d   = sel_s;
      cmpl_tag_d   = tag_d[sel_s];
      cmpl_err_d   = err_d[sel_s];
    end else begin
      cmpl_valid_d = 1'b0;
      cmpl_mvu_d   = '0;
      cmpl_tag_d   = '0;
      cmpl_err_d   = 1'b0;
    end
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_mvu_q   <= '0;
      fifo_tag_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      st_q         <= '0;
      wd_q         <= '0;
      tag_q        <= '0;
      err_q        <= '0;
      start_q      <= '0;
      irq_q        <= '0;
      spur_q       <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_mvu_q   <= '0;
      cmpl_tag_q   <= '0;
      cmpl_err_q   <= 1'b0;
    end else begin
      fifo_mvu_q   <= fifo_mvu_d;
      fifo_tag_q   <= fifo_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      st_q         <= st_d;
      wd_q         <= wd_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      start_q      <= start_d;
      irq_q        <= irq_d;
      spur_q       <= spur_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_mvu_q   <= cmpl_mvu_d;
      cmpl_tag_q   <= cmpl_tag_d;
      cmpl_err_q   <= cmpl_err_d;
    end
  end

  // busy covers both running and awaiting-completion MVUs.
  always_comb begin
    for (int i = 0; i < NMVU; i++) begin
      busy_s[i] = (st_q[i] != ST_IDLE);
    end
  end

  assign job_ready    = job_ready_s;
  assign mvu_start    = start_q;
  assign mvu_irq      = irq_q;
  assign busy         = busy_s;
  assign q_count      = count_q;
  assign cmpl_valid   = cmpl_valid_q;
  assign cmpl_mvu     = cmpl_mvu_q;
  assign cmpl_tag     = cmpl_tag_q;
  assign cmpl_err     = cmpl_err_q;
  assign err_spurious = spur_q;

endmodule

// File: tb/tb_mvu_job_scheduler.sv
module tb_mvu_job_scheduler;
  localparam int NMVU = 8;
  localparam int DEPTH = 4;
  localparam int TAGW = 8;
  localparam int TOW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_valid;
  logic       job_ready;
  logic [2:0] job_mvu;
  logic [7:0] job_tag;
  logic [7:0] mvu_start;
  logic [7:0] mvu_done;
  logic [7:0] mvu_irq;
  logic [7:0] busy;
  logic [2:0] q_count;
  logic       cmpl_valid;
  logic       cmpl_ready;
  logic [2:0] cmpl_mvu;
  logic [7:0] cmpl_tag;
  logic       cmpl_err;
  logic       err_spurious;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mvu_job_scheduler #(.NMVU(NMVU), .DEPTH(DEPTH), .TAGW(TAGW), .TOW(TOW)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_mvu(job_mvu), .job_tag(job_tag),
    .mvu_start(mvu_start), .mvu_done(mvu_done), .mvu_irq(mvu_irq), .busy(busy),
    .q_count(q_count), .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
    .cmpl_mvu(cmpl_mvu), .cmpl_tag(cmpl_tag), .cmpl_err(cmpl_err),
    .err_spurious(err_spurious)
  );

  typedef struct {
    logic       vld;
    logic [2:0] mvu;
    logic [7:0] tag;
    logic [7:0] done;
    logic       rdy;
    logic [7:0] e_start;
    logic [7:0] e_irq;
    logic [7:0] e_busy;
    logic [2:0] e_q;
    logic       e_cv;
    logic [2:0] e_cmvu;
    logic [7:0] e_ctag;
    logic       e_cerr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    job_valid  = 1'b0;
    job_mvu    = 3'd0;
    job_tag    = 8'h00;
    mvu_done   = 8'h00;
    cmpl_ready = 1'b0;
  endtask

  task automatic check_reset(input string p);
    chk({p, " job_ready"}, 32'(job_ready), 32'd1);
    chk({p, " mvu_start"}, 32'(mvu_start), 32'd0);
    chk({p, " mvu_irq"}, 32'(mvu_irq), 32'd0);
    chk({p, " busy"}, 32'(busy), 32'd0);
    chk({p, " q_count"}, 32'(q_count), 32'd0);
    chk({p, " cmpl_valid"}, 32'(cmpl_valid), 32'd0);
    chk({p, " cmpl_mvu"}, 32'(cmpl_mvu), 32'd0);
    chk({p, " cmpl_tag"}, 32'(cmpl_tag), 32'd0);
    chk({p, " cmpl_err"}, 32'(cmpl_err), 32'd0);
    chk({p, " err_spurious"}, 32'(err_spurious), 32'd0);
  endtask

  task automatic push1(input logic [2:0] m, input logic [7:0] t);
    job_valid = 1'b1;
    job_mvu   = m;
    job_tag   = t;
    step();
    job_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    // Single job on MVU2, then two simultaneous completions on MVU1/MVU3.
    //          vld   mvu   tag    done   rdy | start  irq    busy   q     cv    cmvu  ctag   cerr
    vecs[0]  = '{1'b1, 3'd2, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h04, 8'h00, 8'h04, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h04, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 8'h04, 1'b0, 8'h00, 8'h04, 8'h04, 3'd0, 1'b1, 3'd2, 8'h5A, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h04, 3'd0, 1'b1, 3'd2, 8'h5A, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 3'd1, 8'h31, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 3'd3, 8'h33, 8'h00, 1'b0, 8'h02, 8'h00, 8'h02, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h08, 8'h00, 8'h0A, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h0A, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 8'h0A, 1'b1, 8'h00, 8'h0A, 8'h0A, 3'd0, 1'b1, 3'd1, 8'h31, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h08, 3'd0, 1'b1, 3'd3, 8'h33, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0};

    // Reset
    rst_n = 1'b0;
    idle_in();
    step();
    step();
    check_reset("rst");
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      job_valid  = vecs[i].vld;
      job_mvu    = vecs[i].mvu;
      job_tag    = vecs[i].tag;
      mvu_done   = vecs[i].done;
      cmpl_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d start", i), 32'(mvu_start), 32'(vecs[i].e_start));
      chk($sformatf("v%0d irq", i), 32'(mvu_irq), 32'(vecs[i].e_irq));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d q_count", i), 32'(q_count), 32'(vecs[i].e_q));
      chk($sformatf("v%0d cmpl_valid", i), 32'(cmpl_valid), 32'(vecs[i].e_cv));
      chk($sformatf("v%0d cmpl_mvu", i), 32'(cmpl_mvu), 32'(vecs[i].e_cmvu));
      chk($sformatf("v%0d cmpl_tag", i), 32'(cmpl_tag), 32'(vecs[i].e_ctag));
      chk($sformatf("v%0d cmpl_err", i), 32'(cmpl_err), 32'(vecs[i].e_cerr));
    end
    idle_in();

    // Full FIFO and backpressure on MVU0
    push1(3'd0, 8'hA0);
    step();
    chk("t2 start A0", 32'(mvu_start), 32'h01);
    for (int k = 1; k <= 4; k++) begin
      push1(3'd0, 8'hA0 + 8'(k));
      chk($sformatf("t2 q_count fill %0d", k), 32'(q_count), 32'(k));
    end
    chk("t2 job_ready full", 32'(job_ready), 32'd0);
    push1(3'd0, 8'hA5);
    chk("t2 q_count no 5th push", 32'(q_count), 32'd4);
    mvu_done = 8'h01;
    step();
    mvu_done = 8'h00;
    chk("t2 irq A0", 32'(mvu_irq), 32'h01);
    chk("t2 cmpl_tag A0", 32'(cmpl_tag), 32'hA0);
    for (int k = 1; k <= 4; k++) begin
      cmpl_ready = 1'b1;
      step();
      cmpl_ready = 1'b0;
      chk($sformatf("t2 cmpl_valid drop %0d", k), 32'(cmpl_valid), 32'd0);
      chk($sformatf("t2 no start on hs %0d", k), 32'(mvu_start), 32'h00);
      step();
      chk($sformatf("t2 start %0d", k), 32'(mvu_start), 32'h01);
      chk($sformatf("t2 q_count drain %0d", k), 32'(q_count), 32'(4 - k));
      chk($sformatf("t2 job_ready %0d", k), 32'(job_ready), 32'd1);
      mvu_done = 8'h01;
      step();
      mvu_done = 8'h00;
      chk($sformatf("t2 cmpl_tag %0d", k), 32'(cmpl_tag), 32'(8'hA0 + 8'(k)));
      chk($sformatf("t2 cmpl_err %0d", k), 32'(cmpl_err), 32'd0);
    end
    cmpl_ready = 1'b1;
    step();
    cmpl_ready = 1'b0;
    step();
    chk("t2 idle busy", 32'(busy), 32'h00);
    chk("t2 no 5th dispatch", 32'(mvu_start), 32'h00);

    // Head-of-line blocking
    push1(3'd0, 8'h0A);
    push1(3'd0, 8'h0B);
    chk("t3 start 0A", 32'(mvu_start), 32'h01);
    push1(3'd1, 8'h0C);
    chk("t3 q_count", 32'(q_count), 32'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t3 blocked busy %0d", k), 32'(busy), 32'h01);
    end
    mvu_done = 8'h01;
    step();
    mvu_done = 8'h00;
    chk("t3 cmpl_tag 0A", 32'(cmpl_tag), 32'h0A);
    cmpl_ready = 1'b1;
    step();
    cmpl_ready = 1'b0;
    chk("t3 no start on hs", 32'(mvu_start), 32'h00);
    step();
    chk("t3 start 0B", 32'(mvu_start), 32'h01);
    step();
    chk("t3 start 0C", 32'(mvu_start), 32'h02);
    chk("t3 busy both", 32'(busy), 32'h03);
    mvu_done = 8'h03;
    cmpl_ready = 1'b1;
    step();
    mvu_done = 8'h00;
    chk("t3 irq both", 32'(mvu_irq), 32'h03);
    chk("t3 cmpl_tag 0B", 32'(cmpl_tag), 32'h0B);
    step();
    chk("t3 cmpl_mvu 1", 32'(cmpl_mvu), 32'd1);
    chk("t3 cmpl_tag 0C", 32'(cmpl_tag), 32'h0C);
    step();
    cmpl_ready = 1'b0;
    chk("t3 cmpl_valid end", 32'(cmpl_valid), 32'd0);

    // Watchdog timeout on MVU5 (TOW=4: 15 busy cycles)
    push1(3'd5, 8'h77);
    step();
    chk("t5 start", 32'(mvu_start), 32'h20);
    for (int k = 0; k < 14; k++) begin
      step();
      chk($sformatf("t5 no early irq %0d", k), 32'(mvu_irq), 32'h00);
    end
    step();
    chk("t5 irq", 32'(mvu_irq), 32'h20);
    chk("t5 cmpl_valid", 32'(cmpl_valid), 32'd1);
    chk("t5 cmpl_mvu", 32'(cmpl_mvu), 32'd5);
    chk("t5 cmpl_tag", 32'(cmpl_tag), 32'h77);
    chk("t5 cmpl_err", 32'(cmpl_err), 32'd1);
    chk("t5 err_spurious clear", 32'(err_spurious), 32'd0);
    mvu_done = 8'h20;
    step();
    mvu_done = 8'h00;
    chk("t5 err_spurious set", 32'(err_spurious), 32'd1);
    cmpl_ready = 1'b1;
    step();
    cmpl_ready = 1'b0;
    chk("t5 busy cleared", 32'(busy), 32'h00);
    chk("t5 err_spurious sticky", 32'(err_spurious), 32'd1);

    // Reset mid-operation
    push1(3'd2, 8'h01);
    push1(3'd4, 8'h02);
    push1(3'd2, 8'h03);
    push1(3'd2, 8'h04);
    push1(3'd2, 8'h05);
    chk("t6 busy before reset", 32'(busy), 32'h14);
    chk("t6 q_count before reset", 32'(q_count), 32'd3);
    rst_n = 1'b0;
    step();
    check_reset("t6");
    rst_n = 1'b1;
    push1(3'd3, 8'h99);
    step();
    chk("t6 start after reset", 32'(mvu_start), 32'h08);
    mvu_done = 8'h04;
    step();
    mvu_done = 8'h00;
    chk("t6 spurious after reset", 32'(err_spurious), 32'd1);
    chk("t6 no irq for spurious", 32'(mvu_irq), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
